// File: rtl/xcore_shift_pkg.sv
// Shared definitions for the xcore sequential shifter: operation codes and FSM states.
package xcore_shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } shift_state_e;

endpackage

// File: rtl/xcore_shift_step.sv
// Combinational one-step shifter: moves data by STEP bit positions in the direction
// selected by op, each result bit picked by a 4-way select over the four operations.
module xcore_shift_step
   import xcore_shift_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int STEP   = 1
) (
   input  logic [DATA_W-1:0] data,
   input  shift_op_e         op,
   output logic [DATA_W-1:0] result
);

   for (genvar i = 0; i < DATA_W; i++) begin : g_bit
      logic sll_b;
      logic srl_b;
      logic sra_b;
      logic ror_b;
      logic sel_b;

      if (i >= STEP) begin : g_sll_src
         assign sll_b = data[i-STEP];
      end else begin : g_sll_fill
         assign sll_b = 1'b0;
      end

      // Right shifts: logical fills with zero, arithmetic replicates the sign bit.
      if (i + STEP < DATA_W) begin : g_sr_src
         assign srl_b = data[i+STEP];
         assign sra_b = data[i+STEP];
      end else begin : g_sr_fill
         assign srl_b = 1'b0;
         assign sra_b = data[DATA_W-1];
      end

      assign ror_b = data[(i+STEP) % DATA_W];

      // Per-bit operation select.
      always_comb begin
         sel_b = 1'b0;
         case (op)
            OP_SLL:  sel_b = sll_b;
            OP_SRL:  sel_b = srl_b;
            OP_SRA:  sel_b = sra_b;
            OP_ROR:  sel_b = ror_b;
            default: sel_b = 1'b0;
         endcase
      end

      assign result[i] = sel_b;
   end

endmodule

// File: rtl/xcore_shift_seq.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR) with valid/ready handshakes on both sides.
// Build option XCORE_SHIFT_FAST_EN: step 4 bits per cycle while at least 4 remain.
module xcore_shift_seq
   import xcore_shift_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CNT_W-1:0]  in_shamt,
   input  logic [1:0]        in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   shift_state_e      state_r;
   shift_state_e      state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [DATA_W-1:0] work_r;
   shift_op_e         op_r;
   logic [DATA_W-1:0] step1_data_s;
   logic [DATA_W-1:0] step_data_s;
   logic [CNT_W-1:0]  cnt_dec_s;

   xcore_shift_step #(
      .DATA_W (DATA_W),
      .STEP   (1)
   ) u_step1 (
      .data   (work_r),
      .op     (op_r),
      .result (step1_data_s)
   );

`ifdef XCORE_SHIFT_FAST_EN
   logic [DATA_W-1:0] step4_data_s;

   xcore_shift_step #(
      .DATA_W (DATA_W),
      .STEP   (4)
   ) u_step4 (
      .data   (work_r),
      .op     (op_r),
      .result (step4_data_s)
   );

   // Take the wide step while it cannot overshoot the remaining count.
   always_comb begin
      step_data_s = step1_data_s;
      cnt_dec_s   = CNT_W'(3'd1);
      if (cnt_r >= CNT_W'(3'd4)) begin
         step_data_s = step4_data_s;
         cnt_dec_s   = CNT_W'(3'd4);
      end else begin
         step_data_s = step1_data_s;
         cnt_dec_s   = CNT_W'(3'd1);
      end
   end
`else
   // Single-bit stepping only.
   always_comb begin
      step_data_s = step1_data_s;
      cnt_dec_s   = CNT_W'(3'd1);
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; DONE always returns to IDLE so no accept can overlap a take.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_nxt_s = ST_SHIFT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == {CNT_W{1'b0}}) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Operand capture on accept, then one step per SHIFT cycle until the count is spent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= {CNT_W{1'b0}};
         work_r <= {DATA_W{1'b0}};
         op_r   <= OP_SLL;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  work_r <= in_data;
                  cnt_r  <= in_shamt;
                  op_r   <= shift_op_e'(in_op);
               end
            end
            ST_SHIFT: begin
               if (cnt_r != {CNT_W{1'b0}}) begin
                  work_r <= step_data_s;
                  cnt_r  <= cnt_r - cnt_dec_s;
               end
            end
            ST_DONE: begin
               work_r <= work_r;
            end
            default: begin
               cnt_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Handshake outputs decode directly from the state flops.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = work_r;
      case (state_r)
         ST_IDLE:  in_ready = 1'b1;
         ST_SHIFT: busy     = 1'b1;
         ST_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready = 1'b0;
      endcase
   end

endmodule

// File: doc/xcore_shift_seq.md
XCORE_SHIFT_SEQ -- requirements
Module: xcore_shift_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter CNT_W, default 5, shift-amount width ($clog2(DATA_W)).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port in_data, input, DATA_W, operand.
REQ-008 SHALL have port in_shamt, input, CNT_W, shift amount N.
REQ-009 SHALL have port in_op, input, 2, 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes result.
REQ-012 SHALL have port out_data, output, DATA_W, result.
REQ-013 SHALL have port busy, output, 1, high in SHIFT or DONE.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL assert in_ready only in IDLE; accept on in_valid & in_ready: latch in_data, in_shamt into cnt, in_op; go to SHIFT.
REQ-016 SHALL, in SHIFT with cnt != 0, shift the working register one bit per cycle and decrement cnt.
REQ-017 SHALL, in SHIFT with cnt == 0, go to DONE without shifting.
REQ-018 SHALL shift-in 0 for SLL (at LSB) and SRL (at MSB), copy of MSB for SRA, shifted-out bit for ROR.
REQ-019 SHALL give latency N+1 cycles from accept edge to out_valid high (default build).
REQ-020 SHALL hold out_valid and out_data stable in DONE until out_ready; on out_valid & out_ready go to IDLE.
REQ-021 SHALL not accept a new request in the same cycle a result is taken (in_ready low in DONE).
REQ-022 SHALL drive out_data from the working register; value in non-DONE states is don't-care for consumers.
REQ-023 SHALL ignore in_data/in_shamt/in_op changes after accept.
REQ-024 SHALL treat N=0 as a pass-through with latency 1.

Reset
REQ-025 SHALL on rst force state IDLE, cnt 0, working register 0, in_ready 1, out_valid 0, busy 0, out_data 0.
REQ-026 SHALL abort any in-flight operation on rst mid-SHIFT or mid-DONE with no result emitted.

Configuration
REQ-027 SHALL support macro XCORE_SHIFT_FAST_EN: when defined, SHIFT steps 4 bits per cycle while cnt >= 4, else 1 bit; latency = N/4 + N%4 + 1 (integer division).
REQ-028 SHALL, without XCORE_SHIFT_FAST_EN, step exactly 1 bit per cycle and contain no 4-bit step logic.

Structure
REQ-029 SHALL take op encodings (SLL/SRL/SRA/ROR) and FSM state encodings from shared package xcore_shift_pkg.
REQ-030 SHALL instantiate sub-module xcore_shift_step: combinational one-step shifter (data, op, step size) built from per-bit 4-input selects.

Verification
REQ-031 SLL, in_data=0x0000_0001, N=4 -> out_data=0x0000_0010, out_valid 5 cycles after accept.
REQ-032 SRA, in_data=0x8000_0000, N=31 -> out_data=0xFFFF_FFFF; SRL same input -> 0x0000_0001.
REQ-033 ROR, in_data=0x0000_00F1, N=4 -> 0x1000_000F; N=0 any op -> out_data=in_data, latency 1.
REQ-034 out_ready held low 10 cycles in DONE -> out_valid/out_data stable, in_ready low; release -> IDLE next cycle, in_ready high.
REQ-035 rst asserted mid-SHIFT (N=20, cycle 7) -> immediate IDLE, out_valid 0, no result; next request completes normally.
REQ-036 XCORE_SHIFT_FAST_EN defined, SLL N=9 -> correct result with latency 4 (2+1+1).
